// File: rtl/bomberman_pkg.sv
// Shared game constants: tile ids, tile size and the sprite corner ordering
// used when a player probes the tile map.
package bomberman_pkg;

  localparam logic [3:0] TILE_EMPTY     = 4'd0;
  localparam logic [3:0] TILE_BOMB      = 4'd10;
  localparam logic [3:0] TILE_EXPLOSION = 4'd11;
  localparam int         TILE_SIZE      = 16;

  // Probe order around the sprite: top-left, top-right, bottom-left, bottom-right.
  typedef enum logic [1:0] {
    CORNER_TL = 2'd0,
    CORNER_TR = 2'd1,
    CORNER_BL = 2'd2,
    CORNER_BR = 2'd3
  } corner_t;

endpackage

// File: rtl/player_unit_invincibility_timer.sv
// Invincibility-frame counter: loads to INVINC_CYCLES-1 on a hit and counts
// down to zero; the player is invincible while the count is non-zero.
module invincibility_timer #(
  parameter int INVINC_CYCLES = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_load,
  output logic o_active
);

  // Width just large enough to hold INVINC_CYCLES-1 (at least one bit).
  localparam int            TW       = (INVINC_CYCLES > 1) ? $clog2(INVINC_CYCLES) : 1;
  localparam logic [TW-1:0] L_RELOAD = TW'(INVINC_CYCLES - 1);

  logic [TW-1:0] r_count;

  // Round restart clears, a hit reloads, otherwise count down and hold at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= L_RELOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_active = (r_count != '0);

endmodule

// File: rtl/player_unit.sv
// One player's movement and health engine. On each game step it computes a
// candidate position, probes the four sprite corners against the tile map,
// moves only if every corner is empty, and applies explosion damage guarded
// by an invincibility timer.
module player_unit
  import bomberman_pkg::*;
#(
  parameter int COORD_W       = 9,
  parameter int START_X       = 72,
  parameter int START_Y       = 112,
  parameter int MIN_X         = 72,
  parameter int MAX_X         = 232,
  parameter int MIN_Y         = 32,
  parameter int MAX_Y         = 192,
  parameter int SPEED         = 2,
  parameter int SPRITE        = 16,
  parameter int LIVES_W       = 2,
  parameter int LIVES         = 3,
  parameter int INVINC_CYCLES = 100000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_player_reset,
  input  logic               i_step,
  input  logic               i_xmov,
  input  logic               i_xdir,
  input  logic               i_ymov,
  input  logic               i_ydir,
  output logic               o_probe_req,
  output logic [COORD_W-1:0] o_probe_x,
  output logic [COORD_W-1:0] o_probe_y,
  input  logic               i_probe_valid,
  input  logic [3:0]         i_probe_tile,
  input  logic               i_probe_expl,
  output logic [COORD_W-1:0] o_pos_x,
  output logic [COORD_W-1:0] o_pos_y,
  output logic [LIVES_W-1:0] o_lives,
  output logic               o_invincible,
  output logic               o_dead,
  output logic               o_busy,
  output logic               o_step_dropped
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PROBE   = 3'd1;
  localparam logic [2:0] S_DECIDE  = 3'd2;
  localparam logic [2:0] S_REPROBE = 3'd3;
  localparam logic [2:0] S_DECIDE2 = 3'd4;
  localparam logic [2:0] S_COMMIT  = 3'd5;

  // Range arithmetic is one bit wider so that a step below zero wraps to a
  // large value and fails the upper-bound check instead of looking legal.
  localparam logic [COORD_W:0]   L_SPEED   = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0]   L_MIN_X   = (COORD_W+1)'(MIN_X);
  localparam logic [COORD_W:0]   L_MAX_X   = (COORD_W+1)'(MAX_X);
  localparam logic [COORD_W:0]   L_MIN_Y   = (COORD_W+1)'(MIN_Y);
  localparam logic [COORD_W:0]   L_MAX_Y   = (COORD_W+1)'(MAX_Y);
  localparam logic [COORD_W-1:0] L_START_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] L_START_Y = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] L_FAR     = COORD_W'(SPRITE - 1);
  localparam logic [LIVES_W-1:0] L_LIVES   = LIVES_W'(LIVES);

  logic [2:0]         r_state;
  corner_t            r_corner;
  logic [COORD_W-1:0] r_pos_x;
  logic [COORD_W-1:0] r_pos_y;
  logic [COORD_W-1:0] r_cand_x;
  logic [COORD_W-1:0] r_cand_y;
  logic               r_clear;
  logic               r_hit;
  logic               r_accept;
  logic [LIVES_W-1:0] r_lives;
  logic               r_step_dropped;

  logic [COORD_W:0]   w_try_x;
  logic [COORD_W:0]   w_try_y;
  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;
  logic [COORD_W-1:0] w_base_x;
  logic [COORD_W-1:0] w_base_y;
  logic               w_probing;
  logic               w_last_corner;
  logic               w_dead;
  logic               w_invincible;
  logic               w_take_hit;

  function automatic logic [COORD_W:0] move_coord(input logic [COORD_W-1:0] p,
                                                  input logic               dir);
    return dir ? ({1'b0, p} + L_SPEED) : ({1'b0, p} - L_SPEED);
  endfunction

  assign w_try_x = move_coord(r_pos_x, i_xdir);
  assign w_try_y = move_coord(r_pos_y, i_ydir);

  // Candidate position: X request has priority over Y; an out-of-range step
  // leaves that axis where it is (no wrap, no partial step).
  always_comb begin
    w_next_x = r_pos_x;
    w_next_y = r_pos_y;
    if (i_xmov) begin
      if ((w_try_x >= L_MIN_X) && (w_try_x <= L_MAX_X)) begin
        w_next_x = w_try_x[COORD_W-1:0];
      end
    end else if (i_ymov) begin
      if ((w_try_y >= L_MIN_Y) && (w_try_y <= L_MAX_Y)) begin
        w_next_y = w_try_y[COORD_W-1:0];
      end
    end
  end

  // Forward probes test the candidate; the damage-only reprobe tests the
  // position the player actually stays at.
  assign w_base_x  = (r_state == S_REPROBE) ? r_pos_x : r_cand_x;
  assign w_base_y  = (r_state == S_REPROBE) ? r_pos_y : r_cand_y;
  assign o_probe_x = ((r_corner == CORNER_TR) || (r_corner == CORNER_BR)) ? (w_base_x + L_FAR) : w_base_x;
  assign o_probe_y = ((r_corner == CORNER_BL) || (r_corner == CORNER_BR)) ? (w_base_y + L_FAR) : w_base_y;

  assign w_probing     = (r_state == S_PROBE) || (r_state == S_REPROBE);
  assign w_last_corner = (r_corner == CORNER_BR);
  assign w_dead        = (r_lives == '0);
  assign w_take_hit    = (r_state == S_COMMIT) && r_hit && !w_invincible && !w_dead;

  invincibility_timer #(
    .INVINC_CYCLES(INVINC_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (i_player_reset),
    .i_load   (w_take_hit),
    .o_active (w_invincible)
  );

  // Step sequencer: latch candidate, walk the corners, decide, then commit
  // the move and any damage. A round restart aborts everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_corner       <= CORNER_TL;
      r_pos_x        <= L_START_X;
      r_pos_y        <= L_START_Y;
      r_cand_x       <= L_START_X;
      r_cand_y       <= L_START_Y;
      r_clear        <= 1'b0;
      r_hit          <= 1'b0;
      r_accept       <= 1'b0;
      r_lives        <= L_LIVES;
      r_step_dropped <= 1'b0;
    end else if (i_player_reset) begin
      r_state        <= S_IDLE;
      r_corner       <= CORNER_TL;
      r_pos_x        <= L_START_X;
      r_pos_y        <= L_START_Y;
      r_cand_x       <= L_START_X;
      r_cand_y       <= L_START_Y;
      r_clear        <= 1'b0;
      r_hit          <= 1'b0;
      r_accept       <= 1'b0;
      r_lives        <= L_LIVES;
      r_step_dropped <= 1'b0;
    end else begin
      r_step_dropped <= i_step && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_step && !w_dead) begin
            r_cand_x <= w_next_x;
            r_cand_y <= w_next_y;
            r_clear  <= 1'b1;
            r_hit    <= 1'b0;
            r_accept <= 1'b0;
            r_corner <= CORNER_TL;
            r_state  <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (i_probe_valid) begin
            r_clear <= r_clear && (i_probe_tile == TILE_EMPTY);
            r_hit   <= r_hit || i_probe_expl;
            if (w_last_corner) begin
              r_state <= S_DECIDE;
            end else begin
              r_corner <= corner_t'(r_corner + 2'd1);
            end
          end
        end
        S_DECIDE: begin
          r_corner <= CORNER_TL;
          if (r_clear) begin
            r_accept <= 1'b1;
            r_state  <= S_COMMIT;
          end else if ((r_cand_x != r_pos_x) || (r_cand_y != r_pos_y)) begin
            // Blocked move: damage must come from where the player stays.
            r_accept <= 1'b0;
            r_hit    <= 1'b0;
            r_state  <= S_REPROBE;
          end else begin
            r_accept <= 1'b0;
            r_state  <= S_COMMIT;
          end
        end
        S_REPROBE: begin
          if (i_probe_valid) begin
            r_hit <= r_hit || i_probe_expl;
            if (w_last_corner) begin
              r_state <= S_DECIDE2;
            end else begin
              r_corner <= corner_t'(r_corner + 2'd1);
            end
          end
        end
        S_DECIDE2: begin
          r_corner <= CORNER_TL;
          r_state  <= S_COMMIT;
        end
        S_COMMIT: begin
          if (r_accept) begin
            r_pos_x <= r_cand_x;
            r_pos_y <= r_cand_y;
          end
          if (w_take_hit) begin
            r_lives <= r_lives - 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_probe_req    = w_probing;
  assign o_pos_x        = r_pos_x;
  assign o_pos_y        = r_pos_y;
  assign o_lives        = r_lives;
  assign o_invincible   = w_invincible;
  assign o_dead         = w_dead;
  assign o_busy         = (r_state != S_IDLE);
  assign o_step_dropped = r_step_dropped;

endmodule

// File: tb/tb_player_unit.sv
// Directed bench for player_unit with a small tile-map responder: a vertical
// wall at probe_x >= wall_x, a single explosion point, and a programmable
// answer delay.
`timescale 1ns/1ps
module tb_player_unit;

  logic       clk;
  logic       reset;
  logic       player_reset;
  logic       step;
  logic       xmov, xdir, ymov, ydir;
  logic       probe_req;
  logic [8:0] probe_x, probe_y;
  logic       probe_valid;
  logic [3:0] probe_tile;
  logic       probe_expl;
  logic [8:0] pos_x, pos_y;
  logic [1:0] lives;
  logic       invincible, dead, busy, step_dropped;

  int total;
  int bad;

  int wall_x;
  int expl_x;
  int expl_y;
  int resp_delay;
  int wait_cnt;
  int req_n;
  int log_n;
  logic [8:0] log_x [0:2047];

  player_unit #(.INVINC_CYCLES(20)) dut (
    .clock          (clk),
    .reset          (reset),
    .i_player_reset (player_reset),
    .i_step         (step),
    .i_xmov         (xmov),
    .i_xdir         (xdir),
    .i_ymov         (ymov),
    .i_ydir         (ydir),
    .o_probe_req    (probe_req),
    .o_probe_x      (probe_x),
    .o_probe_y      (probe_y),
    .i_probe_valid  (probe_valid),
    .i_probe_tile   (probe_tile),
    .i_probe_expl   (probe_expl),
    .o_pos_x        (pos_x),
    .o_pos_y        (pos_y),
    .o_lives        (lives),
    .o_invincible   (invincible),
    .o_dead         (dead),
    .o_busy         (busy),
    .o_step_dropped (step_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign probe_valid = probe_req && (wait_cnt >= resp_delay);
  assign probe_tile  = (int'(probe_x) >= wall_x) ? 4'd3 : 4'd0;
  assign probe_expl  = (int'(probe_x) == expl_x) && (int'(probe_y) == expl_y);

  // Map responder bookkeeping: wait counter, request-cycle count, probe log.
  always @(posedge clk) begin
    if (!probe_req || probe_valid) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
    if (probe_req) req_n <= req_n + 1;
    if (probe_req && probe_valid) begin
      log_x[log_n] <= probe_x;
      log_n <= log_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic xm, input logic xd, input logic ym, input logic yd,
                         output int ticks);
    xmov = xm; xdir = xd; ymov = ym; ydir = yd;
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks = 1;
    while (busy && ticks < 200) begin
      tick();
      ticks++;
    end
    xmov = 0; xdir = 0; ymov = 0; ydir = 0;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t;
    int base;
    int rbase;
    total = 0; bad = 0;
    wait_cnt = 0; req_n = 0; log_n = 0;
    wall_x = 1000; expl_x = -1; expl_y = -1; resp_delay = 0;
    reset = 1'b1; player_reset = 0; step = 0;
    xmov = 0; xdir = 0; ymov = 0; ydir = 0;
    wait_ticks(3);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_pos_x", pos_x, 72);
    check("rst_pos_y", pos_y, 112);
    check("rst_lives", lives, 3);
    check("rst_invinc", invincible, 0);
    check("rst_dead", dead, 0);
    check("rst_busy", busy, 0);
    check("rst_req", probe_req, 0);
    check("rst_drop", step_dropped, 0);

    // -X at MIN_X: 70 is out of range, stays at 72 and probes at 72
    base = log_n;
    do_step(1, 0, 0, 0, t);
    check("minx_lat", t, 7);
    check("minx_pos", pos_x, 72);
    check("minx_probe0", log_x[base], 72);

    // +X with cycle-accurate timing, step in cycle 0
    rbase = req_n;
    xmov = 1; xdir = 1; step = 1;
    tick();                                   // cycle 1
    step = 0; xmov = 0; xdir = 0;
    check("c1_busy", busy, 1);
    check("c1_req", probe_req, 1);
    check("c1_px", probe_x, 74);
    check("c1_py", probe_y, 112);
    tick();                                   // cycle 2
    check("c2_px_tr", probe_x, 89);
    wait_ticks(3);                            // cycle 5
    check("c5_busy", busy, 1);
    check("c5_req", probe_req, 0);
    tick();                                   // cycle 6
    check("c6_pos", pos_x, 72);
    tick();                                   // cycle 7
    check("c7_pos", pos_x, 74);
    check("c7_busy", busy, 0);
    check("c7_reqs", req_n - rbase, 4);

    // xmov and ymov together: X wins
    do_step(1, 1, 1, 1, t);
    check("prio_x", pos_x, 76);
    check("prio_y", pos_y, 112);
    do_step(0, 0, 1, 0, t);
    check("minus_y", pos_y, 110);

    // Walk to MAX_X
    for (int i = 0; i < 78; i++) do_step(1, 1, 0, 0, t);
    check("walk_x", pos_x, 232);

    // +X at MAX_X: candidate equals pos, probes stay inside the range
    base = log_n;
    do_step(1, 1, 0, 0, t);
    check("maxx_pos", pos_x, 232);
    check("maxx_lat", t, 7);
    check("maxx_tl", log_x[base], 232);
    check("maxx_tr", log_x[base+1], 247);

    // Wall on the right corners while moving -X: reject, reprobe at old pos
    wall_x = 240;
    base = log_n; rbase = req_n;
    do_step(1, 0, 0, 0, t);
    check("wall_pos", pos_x, 232);
    check("wall_lat", t, 12);
    check("wall_reqs", req_n - rbase, 8);
    check("wall_cand_tl", log_x[base], 230);
    check("wall_reprobe_tl", log_x[base+4], 232);
    check("wall_lives", lives, 3);
    wall_x = 1000;

    // Explosion on BL of candidate (230,125)
    expl_x = 230; expl_y = 125;
    do_step(1, 0, 0, 0, t);
    check("hit1_pos", pos_x, 230);
    check("hit1_lives", lives, 2);
    check("hit1_inv", invincible, 1);
    // Second hit inside the window is ignored
    expl_x = 228;
    do_step(1, 0, 0, 0, t);
    check("hit2_pos", pos_x, 228);
    check("hit2_lives", lives, 2);
    check("hit2_inv", invincible, 1);
    wait_ticks(25);
    check("inv_expired", invincible, 0);

    expl_x = 230;
    do_step(1, 1, 0, 0, t);
    check("hit3_lives", lives, 1);
    wait_ticks(25);
    expl_x = 232;
    do_step(1, 1, 0, 0, t);
    check("hit4_lives", lives, 0);
    check("hit4_dead", dead, 1);
    check("hit4_pos", pos_x, 232);
    expl_x = -1; expl_y = -1;

    // Step while dead: nothing happens
    rbase = req_n;
    step = 1; xmov = 1; xdir = 0;
    tick();
    step = 0; xmov = 0;
    check("dead_busy", busy, 0);
    check("dead_drop", step_dropped, 0);
    wait_ticks(3);
    check("dead_reqs", req_n - rbase, 0);

    // Round restart from dead, while the timer is still running
    player_reset = 1;
    tick();
    player_reset = 0;
    check("prst_pos_x", pos_x, 72);
    check("prst_pos_y", pos_y, 112);
    check("prst_lives", lives, 3);
    check("prst_dead", dead, 0);
    check("prst_inv", invincible, 0);

    // Slow map: abort during corner 2, step-while-busy pulse
    resp_delay = 3;
    base = log_n;
    xmov = 1; xdir = 1; step = 1;
    tick();
    step = 0; xmov = 0; xdir = 0;
    t = 0;
    while ((log_n - base) < 2 && t < 100) begin
      tick();
      t++;
    end
    check("slow_two_probes", log_n - base, 2);
    step = 1;
    tick();
    step = 0;
    check("drop_pulse", step_dropped, 1);
    check("drop_busy", busy, 1);
    check("bl_req", probe_req, 1);
    check("bl_py", probe_y, 127);
    player_reset = 1; step = 1;
    tick();
    player_reset = 0; step = 0;
    check("abort_req", probe_req, 0);
    check("abort_busy", busy, 0);
    check("abort_drop", step_dropped, 0);
    check("abort_pos", pos_x, 72);
    wait_ticks(10);
    check("abort_quiet_pos", pos_x, 72);
    check("abort_no_probe", log_n - base, 2);

    // Full step through the slow map
    do_step(1, 1, 0, 0, t);
    check("slow_lat", t, 19);
    check("slow_pos", pos_x, 74);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
